// File: rtl/pop_trace_recorder_pkg.sv
// pop_trace_recorder_pkg: shared trace states, entry sizing and field offsets
// Entry layout, MSB first: {timestamp[CTW], tree_id[MTW], payload[MTW+PTW]}
package vpifo_trace_pkg;
   typedef enum logic [1:0] {RECORD, FULL, DRAIN, DONE} state_e;
   localparam int DEF_PTW      = 16;
   localparam int DEF_TREE_NUM = 4;
   localparam int DEF_CTW      = 16;
   localparam int DEF_LOG_SIZE = 16;
   function automatic int entry_bits(int ctw, int tree_num, int ptw);
      return ctw + 2 * $clog2(tree_num) + ptw;
   endfunction
   function automatic int off_tree_id(int tree_num, int ptw);
      return $clog2(tree_num) + ptw;
   endfunction
   function automatic int off_ts(int tree_num, int ptw);
      return 2 * $clog2(tree_num) + ptw;
   endfunction
endpackage

// File: rtl/pop_trace_recorder_if.sv
// pop_trace_recorder_if: pop capture bus plus valid/ready drain port
// master drives pops/finish/ready (task generator + consumer), slave is the recorder
interface pop_trace_recorder_if #(
   parameter int PTW      = 16,
   parameter int TREE_NUM = 4,
   parameter int CTW      = 16
);
   localparam int MTW = $clog2(TREE_NUM);
   localparam int EW  = CTW + 2 * MTW + PTW;
   logic                 pop_out;
   logic [MTW-1:0]       pop_tree_id;
   logic [MTW+PTW-1:0]   pop_data;
   logic                 finish;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [EW-1:0]        rd_data;
   modport master (output pop_out, pop_tree_id, pop_data, finish, rd_ready, input rd_valid, rd_data);
   modport slave  (input pop_out, pop_tree_id, pop_data, finish, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/trace_log_ram.sv
// trace_log_ram: simple dual-port log RAM, sync write, registered read
// clk_i clock; we_i/waddr_i/wdata_i write port; re_i/raddr_i/rdata_o read port (1-cycle latency)
module trace_log_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);
   logic [W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/pop_trace_recorder.sv
// pop_trace_recorder: timestamps task-generator pops into a log RAM, then drains it
// i_clk/i_arst_n clock and async active-low reset; bus: pop capture + drain port;
// o_count entries logged, o_drop_cnt saturating drops, o_overflow sticky, o_done drain complete.
// An empty log reaches DONE one cycle after finish is sampled.
module pop_trace_recorder
   import vpifo_trace_pkg::*;
#(
   parameter int PTW      = DEF_PTW,
   parameter int TREE_NUM = DEF_TREE_NUM,
   parameter int CTW      = DEF_CTW,
   parameter int LOG_SIZE = DEF_LOG_SIZE
) (
   input  logic                      i_clk,
   input  logic                      i_arst_n,
   pop_trace_recorder_if.slave       bus,
   output logic [$clog2(LOG_SIZE):0] o_count,
   output logic [CTW-1:0]            o_drop_cnt,
   output logic                      o_overflow,
   output logic                      o_done
);
   localparam int AW = $clog2(LOG_SIZE);
   localparam int CW = AW + 1;
   localparam int EW = entry_bits(CTW, TREE_NUM, PTW);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, rptr_q, rptr_d;
   logic [CTW-1:0] ts_q, drop_q, drop_d;
   logic          ovf_q, ovf_d, out_v_q, out_v_d, skid_v_q, skid_v_d, ram_v_q;
   logic [EW-1:0] out_q, out_d, skid_q, skid_d, ram_rdata;
   logic          we, re, drop, xfer, take, keep, last;
   trace_log_ram #(.DEPTH(LOG_SIZE), .W(EW)) u_ram (
      .clk_i  (i_clk),
      .we_i   (we),
      .waddr_i(cnt_q[AW-1:0]),
      .wdata_i({ts_q, bus.pop_tree_id, bus.pop_data}),
      .re_i   (re),
      .raddr_i(rptr_q[AW-1:0]),
      .rdata_o(ram_rdata)
   );
   // Drain pipeline: RAM read stage -> out register, with a skid register catching
   // the in-flight read when the consumer stalls. keep = two entries would remain.
   always_comb begin
      we       = state_q == RECORD && bus.pop_out;
      drop     = state_q == FULL && bus.pop_out;
      xfer     = out_v_q && bus.rd_ready;
      take     = !out_v_q || xfer;
      keep     = (!take && (skid_v_q || ram_v_q)) || (skid_v_q && ram_v_q);
      re       = state_q == DRAIN && rptr_q != cnt_q && !keep;
      last     = state_q == DRAIN && rptr_q == cnt_q && !ram_v_q && !skid_v_q && take;
      cnt_d    = cnt_q + CW'(we);
      rptr_d   = rptr_q + CW'(re);
      drop_d   = (drop && !(&drop_q)) ? drop_q + CTW'(1) : drop_q;
      ovf_d    = ovf_q || drop;
      out_d    = take ? (skid_v_q ? skid_q : ram_rdata) : out_q;
      out_v_d  = take ? (skid_v_q || ram_v_q) : 1'b1;
      skid_d   = ram_v_q ? ram_rdata : skid_q;
      skid_v_d = take ? (skid_v_q && ram_v_q) : (skid_v_q || ram_v_q);
      state_d  = ((state_q == RECORD || state_q == FULL) && bus.finish) ? DRAIN :
                 (we && cnt_q == CW'(LOG_SIZE - 1)) ? FULL :
                 last ? DONE : state_q;
   end
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q  <= RECORD;
         cnt_q    <= '0;
         rptr_q   <= '0;
         ts_q     <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         out_q    <= '0;
         out_v_q  <= 1'b0;
         skid_q   <= '0;
         skid_v_q <= 1'b0;
         ram_v_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rptr_q   <= rptr_d;
         ts_q     <= ts_q + CTW'(1);
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         out_q    <= out_d;
         out_v_q  <= out_v_d;
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
         ram_v_q  <= re;
      end
   end
   assign bus.rd_valid = out_v_q;
   assign bus.rd_data  = out_q;
   assign o_count      = cnt_q;
   assign o_drop_cnt   = drop_q;
   assign o_overflow   = ovf_q;
   assign o_done       = state_q == DONE;
endmodule

// File: tb/tb_pop_trace_recorder.sv
// tb_pop_trace_recorder: directed vectors for the pop trace recorder (LOG_SIZE=4)
module tb_pop_trace_recorder;
   logic        clk = 1'b0;
   logic        arst_n = 1'b1;
   logic [2:0]  count;
   logic [15:0] drop;
   logic        ovf, done;
   int          vecs = 0, errs = 0, cyc = 0;
   logic [35:0] exp_q[$];
   always #5 clk = ~clk;
   pop_trace_recorder_if #(.PTW(16), .TREE_NUM(4), .CTW(16)) bus ();
   pop_trace_recorder #(.PTW(16), .TREE_NUM(4), .CTW(16), .LOG_SIZE(4)) dut (
      .i_clk     (clk),
      .i_arst_n  (arst_n),
      .bus       (bus),
      .o_count   (count),
      .o_drop_cnt(drop),
      .o_overflow(ovf),
      .o_done    (done)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [35:0] ent(input int ts, input int tid, input int d);
      return {ts[15:0], tid[1:0], d[17:0]};
   endfunction
   task automatic step();
      @(negedge clk);
      cyc++;
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_count"}, count, 0);
      check({tag, "_drop"}, drop, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, bus.rd_valid, 0);
      check({tag, "_data"}, bus.rd_data, 0);
   endtask
   task automatic rst();
      arst_n = 1'b0;
      bus.pop_out = 0; bus.pop_tree_id = 0; bus.pop_data = 0; bus.finish = 0; bus.rd_ready = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check_zero("reset");
      arst_n = 1'b1;
      cyc = 0;
   endtask
   // drive one sampled cycle at edge index k after reset release
   task automatic cyc_in(input int k, input bit p, input int tid, input int d, input bit fin);
      while (cyc < k) step();
      bus.pop_out = p; bus.pop_tree_id = tid[1:0]; bus.pop_data = d[17:0]; bus.finish = fin;
      step();
      bus.pop_out = 0; bus.finish = 0;
   endtask
   task automatic first_valid();
      step();
      check("pre_valid", bus.rd_valid, 0);
      check("pre_done", done, 0);
      step();
      check("first_valid", bus.rd_valid, 1);
   endtask
   // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0...
   task automatic drain(input int mode);
      int n = exp_q.size(), got = 0, first_c = -1, last_c = 0;
      bit held = 0;
      logic [35:0] hold_d = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         bus.rd_ready = (mode == 0) || (c % 3 == 0);
         if (held) begin
            check("stall_valid", bus.rd_valid, 1);
            check("stall_data", bus.rd_data, hold_d);
         end
         held = bus.rd_valid && !bus.rd_ready;
         hold_d = bus.rd_data;
         if (bus.rd_valid && bus.rd_ready) begin
            check("drain_data", bus.rd_data, exp_q[got]);
            if (first_c < 0) first_c = c;
            last_c = c;
            got++;
         end
         step();
      end
      bus.rd_ready = 0;
      check("drain_xfers", got, n);
      if (mode == 0) check("no_bubbles", last_c - first_c, n - 1);
      check("done_after", done, 1);
      check("valid_after", bus.rd_valid, 0);
      exp_q.delete();
   endtask
   initial begin
      #1 arst_n = 1'b0;
      // basic capture and drain
      rst();
      cyc_in(5, 1, 1, 'h00A1, 0);
      cyc_in(6, 1, 2, 'h00B2, 0);
      cyc_in(10, 1, 3, 'h00C3, 0);
      cyc_in(20, 0, 0, 0, 1);
      check("t1_count", count, 3);
      check("t1_drop", drop, 0);
      first_valid();
      exp_q.push_back(ent(5, 1, 'h00A1));
      exp_q.push_back(ent(6, 2, 'h00B2));
      exp_q.push_back(ent(10, 3, 'h00C3));
      drain(0);
      // overflow, then stalled drain
      rst();
      for (int i = 0; i < 6; i++) cyc_in(2 + i, 1, i % 4, 'h10 + i, 0);
      check("t2_count", count, 4);
      check("t2_drop", drop, 2);
      check("t2_ovf", ovf, 1);
      cyc_in(10, 0, 0, 0, 1);
      first_valid();
      for (int i = 0; i < 4; i++) exp_q.push_back(ent(2 + i, i % 4, 'h10 + i));
      drain(1);
      check("t2_ovf_held", ovf, 1);
      check("t2_drop_held", drop, 2);
      // empty log
      rst();
      cyc_in(3, 0, 0, 0, 1);
      check("t3_valid0", bus.rd_valid, 0);
      check("t3_done0", done, 0);
      step();
      check("t3_done1", done, 1);
      check("t3_valid1", bus.rd_valid, 0);
      repeat (3) step();
      check("t3_valid_late", bus.rd_valid, 0);
      check("t3_done_late", done, 1);
      check("t3_count", count, 0);
      // pop with finish at count 2, pops ignored in drain
      rst();
      cyc_in(1, 1, 0, 'h1111, 0);
      cyc_in(2, 1, 1, 'h2222, 0);
      cyc_in(4, 1, 2, 'h3FFFF, 1);
      check("t4_count", count, 3);
      bus.pop_out = 1;
      first_valid();
      exp_q.push_back(ent(1, 0, 'h1111));
      exp_q.push_back(ent(2, 1, 'h2222));
      exp_q.push_back(ent(4, 2, 'h3FFFF));
      drain(0);
      bus.pop_out = 0;
      check("t4_count_after", count, 3);
      check("t4_drop", drop, 0);
      check("t4_ovf", ovf, 0);
      // reset mid-drain
      rst();
      cyc_in(1, 1, 1, 'h0001, 0);
      cyc_in(2, 1, 2, 'h0002, 0);
      cyc_in(3, 1, 3, 'h0003, 0);
      cyc_in(5, 0, 0, 0, 1);
      first_valid();
      bus.rd_ready = 1;
      check("t5_first", bus.rd_data, ent(1, 1, 'h0001));
      step();
      bus.rd_ready = 0;
      #2 arst_n = 1'b0;
      #1 check_zero("t5_async");
      @(negedge clk);
      arst_n = 1'b1;
      cyc = 0;
      cyc_in(3, 1, 3, 'h5A5A, 0);
      cyc_in(4, 0, 0, 0, 1);
      check("t5_count", count, 1);
      first_valid();
      exp_q.push_back(ent(3, 3, 'h5A5A));
      drain(0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
